// File: rtl/latency_catch_buffer_if.sv
// Handshake bundle for latency_catch_buffer: producer credit, pipeline catch port,
// consumer valid/ready head and status. The slave modport is the buffer side.
interface latency_catch_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  issue_in;
  logic                  issue_ok;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [CW-1:0]         occupancy;
  logic [CW-1:0]         inflight;
  logic                  protocol_err;

  modport master (
    output issue_in, pipe_valid, pipe_data, out_ready,
    input  issue_ok, out_valid, out_data, occupancy, inflight, protocol_err
  );

  modport slave (
    input  issue_in, pipe_valid, pipe_data, out_ready,
    output issue_ok, out_valid, out_data, occupancy, inflight, protocol_err
  );
endinterface

// File: rtl/latency_catch_buffer.sv
// Catches items leaving a fixed-latency pipe into a circular FIFO (1-cycle catch, FWFT head);
// issue_ok withholds launches once inflight+occupancy reaches DEPTH so a stalled consumer never overflows.
module latency_catch_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  latency_catch_buffer_if.slave  bus
);
  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         occ_q, occ_d;
  logic [CW-1:0]         infl_q, infl_d;
  logic                  err_q, err_d;

  logic [CW:0]           committed;
  logic                  credit_ok;
  logic                  full;
  logic                  head_vld;
  logic                  acc_issue;
  logic                  wr_en;
  logic                  rd_en;
  logic                  infl_dec;

  always_comb begin
    committed = {1'b0, infl_q} + {1'b0, occ_q};
    credit_ok = committed < {1'b0, DEPTH_C};
    full      = (occ_q == DEPTH_C);
    head_vld  = (occ_q != '0);
    acc_issue = bus.issue_in & credit_ok;
    // At full the read still drains the head, so the incoming item is lost.
    wr_en     = bus.pipe_valid & ~full;
    rd_en     = head_vld & bus.out_ready;
    infl_dec  = bus.pipe_valid & (infl_q != '0);

    wr_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;

    rd_ptr_d = rd_ptr_q;
    if (rd_en) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

    occ_d = occ_q;
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    infl_d = infl_q;
    case ({acc_issue, infl_dec})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase

    err_d = err_q
          | (bus.issue_in & ~credit_ok)
          | (bus.pipe_valid & full)
          | (bus.pipe_valid & (infl_q == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.pipe_data;
  end

  assign bus.issue_ok     = credit_ok;
  assign bus.out_valid    = head_vld;
  assign bus.out_data     = mem_q[rd_ptr_q];
  assign bus.occupancy    = occ_q;
  assign bus.inflight     = infl_q;
  assign bus.protocol_err = err_q;
endmodule
